// File: rtl/i2s_sample_scheduler.sv
// ---------------------------------------------------------------------------
// i2s_sample_scheduler
//
// Frame-rate sample scheduler and source arbiter that sits in front of the
// I2S transmitter. Two 16-bit producers are arbitrated (fixed priority or
// round-robin) into a small sample FIFO. Once running, exactly one sample is
// popped per audio frame and held on sample_out for the whole frame. The
// block also owns the transmitter reset release so that frame timing is
// deterministic relative to sample updates.
//
// Ports:
//   input_clk        system clock (12.288 MHz)
//   reset            asynchronous active-low reset
//   enable           run request
//   arb_mode         0 = fixed priority (src0 wins), 1 = round-robin
//   src0_data/valid  source 0 sample and offer
//   src0_ready       source 0 granted this cycle
//   src1_data/valid  source 1 sample and offer
//   src1_ready       source 1 granted this cycle
//   sample_out       sample presented to the transmitter
//   frame_tick       one-cycle pulse aligned with each sample_out update
//   tx_reset_n       active-low transmitter reset
//   fifo_level       current FIFO occupancy
//   underflow_count  saturating count of frames that found the FIFO empty
//   state            00 = IDLE, 01 = PRIME, 10 = RUN
// ---------------------------------------------------------------------------
module i2s_sample_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FRAME_CYCLES   = 256,
  parameter int PRIME_LEVEL    = 2,
  parameter int UNDERFLOW_ZERO = 1
) (
  input  logic                          input_clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          arb_mode,
  input  logic [15:0]                   src0_data,
  input  logic                          src0_valid,
  output logic                          src0_ready,
  input  logic [15:0]                   src1_data,
  input  logic                          src1_valid,
  output logic                          src1_ready,
  output logic [15:0]                   sample_out,
  output logic                          frame_tick,
  output logic                          tx_reset_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underflow_count,
  output logic [1:0]                    state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_CYCLES);

  localparam logic [AW:0]   FULL_LEVEL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PRIME_LVL   = (AW + 1)'(PRIME_LEVEL);
  localparam logic [CW-1:0] LAST_CYCLE  = CW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    RUN   = 2'b10
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_frameCount;
  logic [15:0]     r_sample;
  logic            r_tick;
  logic            r_txResetN;
  logic [7:0]      r_underflow;

  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [AW:0]     r_level;
  // 1 = src1 was granted last, so src0 holds round-robin priority next.
  logic            r_lastGrant;

  logic            w_full;
  logic            w_empty;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_push;
  logic [15:0]     w_pushData;
  logic            w_boundary;
  logic            w_pop;

  assign w_full  = (r_level == FULL_LEVEL);
  assign w_empty = (r_level == '0);

  // Source arbitration. A full FIFO blocks both sources even when a pop is
  // happening this cycle, which keeps ready free of any path from the frame
  // counter. With only one source valid, both modes simply grant it.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!w_full) begin
      if (!arb_mode || !(src0_valid && src1_valid)) begin
        w_grant0 = src0_valid;
        w_grant1 = src1_valid && !src0_valid;
      end else begin
        w_grant0 = r_lastGrant;
        w_grant1 = !r_lastGrant;
      end
    end
  end

  assign src0_ready = w_grant0;
  assign src1_ready = w_grant1;

  assign w_push     = w_grant0 || w_grant1;
  assign w_pushData = w_grant0 ? src0_data : src1_data;

  // The last cycle of a RUN frame is the boundary; the pop happens on the
  // edge that ends it, together with the registered frame_tick.
  assign w_boundary = (r_state == RUN) && (r_frameCount == LAST_CYCLE);
  assign w_pop      = w_boundary && !w_empty;

  // Sample storage has no reset; validity is tracked by the pointers/level.
  always_ff @(posedge input_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_pushData;
    end
  end

  // FIFO pointers, occupancy and round-robin history. Pointers wrap
  // naturally because the depth is a power of two.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_level     <= '0;
      r_lastGrant <= 1'b1;
    end else begin
      if (w_push) begin
        r_wrPtr     <= r_wrPtr + AW'(1);
        r_lastGrant <= w_grant1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW + 1)'(1);
        2'b01:   r_level <= r_level - (AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Scheduler state machine with all outputs registered. In RUN a falling
  // enable is only honoured at the frame boundary, after that boundary's
  // normal pop, so the transmitter never sees a truncated frame.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_frameCount <= '0;
      r_sample     <= '0;
      r_tick       <= 1'b0;
      r_txResetN   <= 1'b0;
      r_underflow  <= '0;
    end else begin
      r_tick <= w_boundary;
      case (r_state)
        IDLE: begin
          r_frameCount <= '0;
          r_txResetN   <= 1'b0;
          if (enable) begin
            r_state <= PRIME;
          end
        end
        PRIME: begin
          r_frameCount <= '0;
          if (!enable) begin
            r_state <= IDLE;
          end else if (r_level >= PRIME_LVL) begin
            r_state    <= RUN;
            r_txResetN <= 1'b1;
          end
        end
        RUN: begin
          if (w_boundary) begin
            r_frameCount <= '0;
            if (!w_empty) begin
              r_sample <= r_mem[r_rdPtr];
            end else begin
              if (UNDERFLOW_ZERO != 0) begin
                r_sample <= '0;
              end
              if (r_underflow != 8'hFF) begin
                r_underflow <= r_underflow + 8'd1;
              end
            end
            if (!enable) begin
              r_state    <= IDLE;
              r_txResetN <= 1'b0;
            end
          end else begin
            r_frameCount <= r_frameCount + CW'(1);
          end
        end
        default: begin
          r_state      <= IDLE;
          r_frameCount <= '0;
          r_txResetN   <= 1'b0;
        end
      endcase
    end
  end

  assign sample_out      = r_sample;
  assign frame_tick      = r_tick;
  assign tx_reset_n      = r_txResetN;
  assign fifo_level      = r_level;
  assign underflow_count = r_underflow;
  assign state           = r_state;

endmodule

// File: doc/i2s_sample_scheduler.md
Name: i2s_sample_scheduler

Overview:
- Frame-rate sample scheduler and source arbiter placed in front of the I2S transmitter.
- Arbitrates two 16-bit audio producers into a small sample FIFO, using either fixed priority or round-robin.
- Pops exactly one sample per 48 kHz frame and holds it stable on sample_out for the transmitter.
- Owns the transmitter's reset release (tx_reset_n) so frame timing is deterministic relative to sample updates.

Parameters:
FIFO_DEPTH, 4, sample FIFO entries; power of two, at least 2.
FRAME_CYCLES, 256, input_clk cycles per audio frame (12.288 MHz / 48 kHz).
PRIME_LEVEL, 2, FIFO entries required before leaving PRIME; range 1 to FIFO_DEPTH.
UNDERFLOW_ZERO, 1, 1 = output 0 on underflow; 0 = repeat the previous sample.

Ports:
input_clk  in  1  system clock, 12.288 MHz
reset  in  1  asynchronous active-low reset
enable  in  1  run request
arb_mode  in  1  0 = fixed priority (src0 wins); 1 = round-robin
src0_data  in  16  source 0 sample
src0_valid  in  1  source 0 offers a sample
src0_ready  out  1  source 0 sample accepted this cycle when valid is also high
src1_data  in  16  source 1 sample
src1_valid  in  1  source 1 offers a sample
src1_ready  out  1  source 1 sample accepted this cycle when valid is also high
sample_out  out  16  sample presented to the transmitter
frame_tick  out  1  one-cycle pulse on every frame boundary in RUN
tx_reset_n  out  1  active-low reset for the transmitter
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
underflow_count  out  8  saturating count of empty-FIFO frames
state  out  2  00 = IDLE, 01 = PRIME, 10 = RUN

Behaviour:
- Reset (async, reset = 0):
  - state = IDLE, FIFO emptied, fifo_level = 0.
  - sample_out = 0, frame_tick = 0, tx_reset_n = 0, underflow_count = 0.
  - Round-robin pointer = src1 last granted, so src0 has first priority.
  - Asserting reset mid-operation aborts immediately; no partial frame completes.
- Arbitration (combinational, every state):
  - A grant is possible only when the FIFO is not full.
  - arb_mode = 0: src0 wins whenever src0_valid = 1.
  - arb_mode = 1: with both sources valid, grant goes to the source not granted last; with one source valid, that source is granted.
  - srcN_ready = grant to source N. ready may depend on valid.
  - At most one push per cycle. The pointer updates only on an actual transfer (valid and ready).
  - Full FIFO: both ready = 0, even in a cycle where a pop occurs.
- FIFO:
  - Push and pop in the same cycle are legal; fifo_level is then unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE:
    - tx_reset_n = 0 and the frame counter is held at 0.
    - Sources may fill the FIFO.
    - enable = 1 -> PRIME.
  - PRIME:
    - enable = 0 -> IDLE.
    - fifo_level >= PRIME_LEVEL -> RUN.
    - On the transition cycle, the frame counter loads 0 and tx_reset_n registers to 1.
  - RUN:
    - The frame counter counts 0 to FRAME_CYCLES-1 and wraps.
    - When the counter = FRAME_CYCLES-1, frame_tick is asserted as a registered pulse in the next cycle, aligned with the sample_out update.
    - Each frame boundary pops one entry into sample_out.
    - If the FIFO is empty at a boundary: sample_out = 0 (UNDERFLOW_ZERO = 1) or held (UNDERFLOW_ZERO = 0), and underflow_count increments, saturating at 255.
    - enable = 0 takes effect only at the next frame boundary: that boundary completes its normal pop, then the block goes to IDLE with tx_reset_n = 0.
    - The FIFO contents are retained when returning to IDLE.
- Latency:
  - A sample pushed into an empty FIFO in RUN appears on sample_out at the next frame boundary.
  - Maximum latency is FIFO_DEPTH frames.
- sample_out changes only in cycles where frame_tick = 1 and is stable for the whole frame.

Test Plan:
1. Reset held, then enable = 1 with src0 pushing 0x1111 then 0x2222 -> PRIME to RUN after the 2nd push; tx_reset_n rises the same cycle; first frame_tick 256 cycles later with sample_out = 0x1111; next frame_tick at +256 with 0x2222.
2. arb_mode = 1, both sources always valid, src0 = 0xA000.., src1 = 0xB000.. -> grants alternate src0, src1, src0...; the FIFO holds A, B, A, B; with arb_mode = 0 the FIFO holds only A values.
3. FIFO full (fifo_level = 4) with both sources valid -> both ready stay 0 until a frame_tick pop, then exactly one push; fifo_level goes 4 -> 3 -> 4.
4. Stop pushing in RUN with UNDERFLOW_ZERO = 1 -> after the FIFO drains, each frame_tick gives sample_out = 0 and underflow_count 1, 2, 3...; forcing 300 underflows leaves underflow_count = 255.
5. enable dropped at counter = 10 -> remains RUN until the boundary; that boundary pops normally, then state = IDLE and tx_reset_n = 0; the remaining FIFO entries are preserved and replayed after re-enable.
6. Async reset asserted at counter = 100 with 3 entries queued -> all outputs immediately return to reset values, fifo_level = 0, and no frame_tick occurs.
